// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared constants, types, FSM encoding and helper functions
//               for the 16-point FFT datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int DATA_W = 17;                 // real / imaginary part width
    localparam int CPLX_W = 2 * DATA_W;         // {re, im}
    localparam int N_PT   = 16;                 // samples per frame
    localparam int LANES  = 4;                  // samples per parallel word
    localparam int WORD_W = LANES * CPLX_W;     // parallel word width

    typedef logic [CPLX_W-1:0] cplx_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    // Reverse the bit order of a 4-bit sample index
    function automatic logic [3:0] bitrev4(input logic [3:0] a);
        return {a[0], a[1], a[2], a[3]};
    endfunction

endpackage : fft_pkg
`default_nettype wire

// File: rtl/s_p_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : s_p_buf_if
// Description : Serial input / parallel output bundle of the s_p_buf block.
//               master = sample source and word consumer, slave = s_p_buf.
// Revision    : 1.0 - initial release
// ============================================================================
interface s_p_buf_if;
    import fft_pkg::*;

    cplx_t       data_in;
    logic        in_valid;
    logic        flush;
    word_t       data_out;
    logic        out_valid;
    logic        frame_start;
    logic [1:0]  word_idx;

    modport master (
        output data_in, in_valid, flush,
        input  data_out, out_valid, frame_start, word_idx
    );

    modport slave (
        input  data_in, in_valid, flush,
        output data_out, out_valid, frame_start, word_idx
    );

endinterface : s_p_buf_if
`default_nettype wire

// File: rtl/s_p_bank.sv
`default_nettype none
// ============================================================================
// Module      : s_p_bank
// Description : 16 x 34b sample bank, one write port, combinational read of
//               four samples at stride 4: {m[12+a], m[8+a], m[4+a], m[a]}.
//               Contents are intentionally not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module s_p_bank
    import fft_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        we_i,
    input  wire logic [3:0]  waddr_i,
    input  wire cplx_t       wdata_i,
    input  wire logic [1:0]  raddr_i,
    output      word_t       rdata_o
);

    cplx_t mem_q [N_PT];

    // Store one sample per write strobe
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Gather the four stride-4 lanes of the selected word
    always_comb begin
        rdata_o = {mem_q[{2'd3, raddr_i}], mem_q[{2'd2, raddr_i}],
                   mem_q[{2'd1, raddr_i}], mem_q[{2'd0, raddr_i}]};
    end

endmodule : s_p_bank
`default_nettype wire

// File: rtl/s_p_buf.sv
`default_nettype none
// ============================================================================
// Module      : s_p_buf
// Description : Serial-to-parallel ping-pong input buffer for the 16-point
//               FFT. Collects 16 serial samples per frame and emits four
//               back-to-back 136b words in radix-4 stride-4 lane order.
//               Optional macro S_P_BITREV_EN: store samples at bit-reversed
//               addresses (same timing).
// Revision    : 1.0 - initial release
// ============================================================================
module s_p_buf
    import fft_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_n,
    s_p_buf_if.slave    bus
);

    logic [3:0] wr_cnt_q;
    logic [3:0] wr_cnt_d;
    logic       wr_bank_q;
    logic       rd_bank_q;
    state_t     state_q;
    logic [1:0] word_idx_q;
    word_t      data_out_q;
    logic       out_valid_q;
    logic       frame_start_q;

    logic       accept;
    logic       last;
    logic [3:0] waddr;
    logic       rd_sel;
    logic [1:0] raddr;
    word_t      rdata0;
    word_t      rdata1;
    word_t      rd_word;

    // Write-side control; the last sample launches word 0 straight from the
    // bank being filled because that sample is not needed until word 3
    always_comb begin
        accept   = bus.in_valid & ~bus.flush;
        last     = accept & (wr_cnt_q == 4'd15);
        wr_cnt_d = wr_cnt_q;
        if (bus.flush) begin
            wr_cnt_d = 4'd0;
        end else if (bus.in_valid) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
        end
`ifdef S_P_BITREV_EN
        waddr    = bitrev4(wr_cnt_q);
`else
        waddr    = wr_cnt_q;
`endif
        rd_sel   = last ? wr_bank_q : rd_bank_q;
        raddr    = last ? 2'd0 : (word_idx_q + 2'd1);
        rd_word  = rd_sel ? rdata1 : rdata0;
    end

    s_p_bank u_bank0 (
        .clk     (clk),
        .we_i    (accept & ~wr_bank_q),
        .waddr_i (waddr),
        .wdata_i (bus.data_in),
        .raddr_i (raddr),
        .rdata_o (rdata0)
    );

    s_p_bank u_bank1 (
        .clk     (clk),
        .we_i    (accept & wr_bank_q),
        .waddr_i (waddr),
        .wdata_i (bus.data_in),
        .raddr_i (raddr),
        .rdata_o (rdata1)
    );

    // Write counter and ping-pong bank selection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q  <= 4'd0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            if (last) begin
                wr_bank_q <= ~wr_bank_q;
                rd_bank_q <= wr_bank_q;
            end
        end
    end

    // Read FSM with registered outputs: four DRAIN words then back to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            data_out_q    <= '0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            word_idx_q    <= 2'd0;
        end else if (last) begin
            state_q       <= S_DRAIN;
            data_out_q    <= rd_word;
            out_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
            word_idx_q    <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    out_valid_q   <= 1'b0;
                    frame_start_q <= 1'b0;
                end
                S_DRAIN: begin
                    frame_start_q <= 1'b0;
                    if (word_idx_q == 2'd3) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end else begin
                        data_out_q  <= rd_word;
                        word_idx_q  <= word_idx_q + 2'd1;
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    out_valid_q   <= 1'b0;
                    frame_start_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.word_idx    = word_idx_q;

endmodule : s_p_buf
`default_nettype wire

// File: tb/tb_s_p_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_s_p_buf
// Description : Directed self-checking bench for s_p_buf (both builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s_p_buf;
    import fft_pkg::*;

`ifdef S_P_BITREV_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    s_p_buf_if bus();

    s_p_buf u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       fs;
        logic [1:0] idx;
        word_t      d;
        int         c;
    } obs_t;

    obs_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Record every valid output word, away from the active edge
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) q.push_back('{bus.frame_start, bus.word_idx, bus.data_out, cyc});
    end

    task automatic chk(input string tag, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic cplx_t smp(input int v);
        return {17'(v), 17'd0};
    endfunction

    function automatic word_t pack4(input int l0, input int l1, input int l2, input int l3);
        return {smp(l3), smp(l2), smp(l1), smp(l0)};
    endfunction

    function automatic word_t exp_word(input int base, input int c);
        word_t      w;
        logic [3:0] a;
        int         i;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            i = 4 * k + c;
            a = i[3:0];
            if (BR) a = {a[0], a[1], a[2], a[3]};
            w[k*CPLX_W +: CPLX_W] = smp(base + int'(a));
        end
        return w;
    endfunction

    task automatic send(input int base, input int n, input bit gaps, output int t_last);
        t_last = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.data_in  = smp(base + i);
            bus.in_valid = 1'b1;
            t_last       = cyc;
            if (gaps && i < n - 1) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.flush    = 1'b0;
        end
    endtask

    task automatic check_frame(input string tag, input int base, input int t_first);
        obs_t o;
        chk({tag, "_nwords"}, 136'(q.size() >= 4), 136'd1);
        for (int c = 0; c < 4; c++) begin
            if (q.size() > 0) begin
                o = q.pop_front();
                chk($sformatf("%s_w%0d_data", tag, c), o.d, exp_word(base, c));
                chk($sformatf("%s_w%0d_idx", tag, c), 136'(o.idx), 136'(c));
                chk($sformatf("%s_w%0d_fs", tag, c), 136'(o.fs), 136'(c == 0));
                chk($sformatf("%s_w%0d_cyc", tag, c), 136'(o.c), 136'(t_first + c));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int t2;
        bus.data_in  = '0;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;

        // Reset state
        #12;
        chk("rst_data", bus.data_out, '0);
        chk("rst_ov", 136'(bus.out_valid), 136'd0);
        chk("rst_fs", 136'(bus.frame_start), 136'd0);
        chk("rst_idx", 136'(bus.word_idx), 136'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: back-to-back frame x=i
        send(0, 16, 1'b0, t);
        idle(1);
        chk("t1_ov_rise", 136'(bus.out_valid), 136'd1);
        idle(5);
        if (q.size() >= 4) begin
            if (BR) begin
                chk("t1_w0_hand", q[0].d, pack4(0, 2, 1, 3));
                chk("t1_w1_hand", q[1].d, pack4(8, 10, 9, 11));
            end else begin
                chk("t1_w0_hand", q[0].d, pack4(0, 4, 8, 12));
                chk("t1_w3_hand", q[3].d, pack4(3, 7, 11, 15));
            end
        end
        check_frame("t1", 0, t + 1);
        chk("t1_extra", 136'(q.size()), 136'd0);

        // 2: same frame with in_valid toggling
        send(0, 16, 1'b1, t);
        chk("t2_ov_pre", 136'(bus.out_valid), 136'd0);
        idle(1);
        chk("t2_ov_rise", 136'(bus.out_valid), 136'd1);
        idle(5);
        check_frame("t2", 0, t + 1);

        // 3: two frames back-to-back
        send(0, 16, 1'b0, t);
        send(100, 16, 1'b0, t2);
        idle(6);
        check_frame("t3a", 0, t + 1);
        check_frame("t3b", 100, t2 + 1);
        chk("t3_extra", 136'(q.size()), 136'd0);

        // 4: flush after 7 samples, flush beats in_valid
        send(20, 7, 1'b0, t);
        @(negedge clk);
        bus.data_in = smp(999); bus.in_valid = 1'b1; bus.flush = 1'b1;
        idle(1);
        send(50, 16, 1'b0, t);
        idle(6);
        check_frame("t4", 50, t + 1);
        chk("t4_extra", 136'(q.size()), 136'd0);

        // 4b: flush together with sample 15 drops the frame
        send(70, 15, 1'b0, t);
        @(negedge clk);
        bus.data_in = smp(85); bus.in_valid = 1'b1; bus.flush = 1'b1;
        idle(8);
        chk("t4b_nodrain", 136'(q.size()), 136'd0);
        send(30, 16, 1'b0, t);
        idle(6);
        check_frame("t4b", 30, t + 1);

        // 5: async reset during drain word 1
        send(0, 16, 1'b0, t);
        idle(2);
        chk("t5_idx1", 136'(bus.word_idx), 136'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_ov", 136'(bus.out_valid), 136'd0);
        chk("t5_data", bus.data_out, '0);
        chk("t5_fs", 136'(bus.frame_start), 136'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        idle(5);
        chk("t5_quiet", 136'(q.size()), 136'd0);
        send(200, 16, 1'b0, t);
        idle(6);
        check_frame("t5", 200, t + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_s_p_buf
`default_nettype wire
